// File: rtl/bp_update_scheduler.sv
// bp_update_scheduler: sequences update writes and flush invalidations
// onto the branch predictor's single table port, yielding to fetch.
module bp_update_scheduler #(
   parameter int DEPTH        = 4,
   parameter int NUM_ENTRIES  = 8,
   parameter int STARVE_LIMIT = 8,
   localparam int IW = (NUM_ENTRIES > 1) ? $clog2(NUM_ENTRIES) : 1
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          upd_valid,
   input  logic [15:0]   upd_pc,
   input  logic [15:0]   upd_target,
   input  logic          upd_taken,
   output logic          upd_ready,
   input  logic          flush_req,
   output logic          flush_busy,
   input  logic          lookup_active,
   output logic          stall_fetch,
   output logic          wr_en,
   output logic [15:0]   wr_pc,
   output logic [15:0]   wr_target,
   output logic          wr_taken,
   output logic          inv_en,
   output logic [IW-1:0] inv_ix
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = PW + 1;
   localparam int SW = $clog2(STARVE_LIMIT + 1);

   typedef enum logic {
      RUN   = 1'b0,
      FLUSH = 1'b1
   } state_e;

   state_e          state_q, state_d;
   logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [CW-1:0]   count_q, count_d;
   logic [IW-1:0]   inv_ix_q, inv_ix_d;
   logic [SW-1:0]   starve_q, starve_d;

   logic [15:0]     pc_mem  [DEPTH];
   logic [15:0]     tgt_mem [DEPTH];
   logic            tk_mem  [DEPTH];

   logic            full;
   logic            empty;
   logic            pending;
   logic            grant;
   logic            push;
   logic            pop;
   logic            clear;
   logic            last_ix;

   assign full    = (count_q == CW'(DEPTH));
   assign empty   = (count_q == '0);
   assign pending = ((state_q == RUN) && !empty) || (state_q == FLUSH);
   assign last_ix = (inv_ix_q == IW'(NUM_ENTRIES - 1));

   // Fetch is held off only once updates have been blocked long enough.
   assign stall_fetch = pending && (starve_q == SW'(STARVE_LIMIT));
   assign grant       = !lookup_active || stall_fetch;

   assign push   = upd_valid && upd_ready;
   assign pop    = wr_en;
   assign inv_ix = inv_ix_q;

   // Head fields are driven only while a write is actually issued.
   assign wr_pc     = wr_en ? pc_mem[rd_ptr_q]  : 16'h0000;
   assign wr_target = wr_en ? tgt_mem[rd_ptr_q] : 16'h0000;
   assign wr_taken  = wr_en ? tk_mem[rd_ptr_q]  : 1'b0;

   // Next-state and port arbitration for the RUN/FLUSH controller.
   always_comb begin
      state_d    = state_q;
      inv_ix_d   = inv_ix_q;
      upd_ready  = 1'b0;
      flush_busy = 1'b0;
      wr_en      = 1'b0;
      inv_en     = 1'b0;
      clear      = 1'b0;
      unique case (state_q)
         RUN: begin
            upd_ready = !full && !flush_req && !reset;
            if (flush_req) begin
               state_d  = FLUSH;
               inv_ix_d = '0;
               clear    = 1'b1;
            end else begin
               wr_en = !empty && grant;
            end
         end
         FLUSH: begin
            flush_busy = 1'b1;
            inv_en     = grant;
            if (inv_en) begin
               if (last_ix) begin
                  state_d  = RUN;
                  inv_ix_d = '0;
               end else begin
                  inv_ix_d = inv_ix_q + IW'(1);
               end
            end
         end
         default: state_d = RUN;
      endcase
   end

   // FIFO pointer and occupancy bookkeeping; a flush drops stale entries.
   always_comb begin
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      if (clear) begin
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push) wr_ptr_d = wr_ptr_q + PW'(1);
         if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
         if (push && !pop)      count_d = count_q + CW'(1);
         else if (!push && pop) count_d = count_q - CW'(1);
      end
   end

   // Count consecutive cycles pending work loses the port to fetch.
   always_comb begin
      starve_d = starve_q;
      if (wr_en || inv_en || !pending) begin
         starve_d = '0;
      end else if (lookup_active && !stall_fetch) begin
         if (starve_q != SW'(STARVE_LIMIT)) starve_d = starve_q + SW'(1);
      end
   end

   // Control state registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= RUN;
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
         inv_ix_q <= '0;
         starve_q <= '0;
      end else begin
         state_q  <= state_d;
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
         inv_ix_q <= inv_ix_d;
         starve_q <= starve_d;
      end
   end

   // Update payload storage; validity is tracked by the pointers.
   always_ff @(posedge clk) begin
      if (push) begin
         pc_mem[wr_ptr_q]  <= upd_pc;
         tgt_mem[wr_ptr_q] <= upd_target;
         tk_mem[wr_ptr_q]  <= upd_taken;
      end
   end

endmodule

// File: tb/tb_bp_update_scheduler.sv
// tb_bp_update_scheduler: scoreboard bench for the predictor
// update scheduler (writes and invalidations checked by a monitor).
module tb_bp_update_scheduler;

   logic        clk = 1'b0;
   logic        reset;
   logic        upd_valid;
   logic [15:0] upd_pc;
   logic [15:0] upd_target;
   logic        upd_taken;
   logic        upd_ready;
   logic        flush_req;
   logic        flush_busy;
   logic        lookup_active;
   logic        stall_fetch;
   logic        wr_en;
   logic [15:0] wr_pc;
   logic [15:0] wr_target;
   logic        wr_taken;
   logic        inv_en;
   logic [2:0]  inv_ix;

   typedef struct packed {
      logic [15:0] pc;
      logic [15:0] tgt;
      logic        tk;
   } upd_t;

   upd_t sb[$];
   int   inv_q[$];
   int   n_cmp = 0;
   int   n_err = 0;

   bp_update_scheduler #(
      .DEPTH(4), .NUM_ENTRIES(8), .STARVE_LIMIT(8)
   ) dut (
      .clk(clk), .reset(reset),
      .upd_valid(upd_valid), .upd_pc(upd_pc),
      .upd_target(upd_target), .upd_taken(upd_taken),
      .upd_ready(upd_ready), .flush_req(flush_req),
      .flush_busy(flush_busy), .lookup_active(lookup_active),
      .stall_fetch(stall_fetch), .wr_en(wr_en),
      .wr_pc(wr_pc), .wr_target(wr_target), .wr_taken(wr_taken),
      .inv_en(inv_en), .inv_ix(inv_ix)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t",
                  nm, act, exp, $time);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // Present one update for a cycle; expected acceptance is hand-derived.
   task automatic drive_upd(input logic [15:0] pc, input logic [15:0] tg,
                            input logic tk, input logic exp_rdy);
      upd_valid  = 1'b1;
      upd_pc     = pc;
      upd_target = tg;
      upd_taken  = tk;
      @(negedge clk);
      chk("upd_ready", 64'(upd_ready), 64'(exp_rdy));
      if (exp_rdy) sb.push_back('{pc: pc, tgt: tg, tk: tk});
      cyc();
      upd_valid = 1'b0;
   endtask

   task automatic expect_walk(input int n);
      for (int i = 0; i < n; i++) inv_q.push_back(i);
   endtask

   // Monitor: every issued write/invalidate must match the queue head.
   always @(negedge clk) begin
      if (!reset) begin
         if (wr_en) begin
            if (sb.size() == 0) begin
               chk("unexpected_wr", 64'(wr_pc), 64'hFFFF_FFFF);
            end else begin
               upd_t e;
               e = sb.pop_front();
               chk("wr_entry", 64'({wr_pc, wr_target, wr_taken}), 64'(e));
            end
         end else if (wr_pc != 0 || wr_target != 0 || wr_taken) begin
            chk("wr_idle_zero", 64'({wr_pc, wr_target, wr_taken}), 64'd0);
         end
         if (inv_en) begin
            if (inv_q.size() == 0) begin
               chk("unexpected_inv", 64'(inv_ix), 64'hFFFF_FFFF);
            end else begin
               int ix;
               ix = inv_q.pop_front();
               chk("inv_ix", 64'(inv_ix), 64'(ix));
            end
         end
      end
   end

   initial begin
      reset         = 1'b1;
      upd_valid     = 1'b0;
      upd_pc        = '0;
      upd_target    = '0;
      upd_taken     = 1'b0;
      flush_req     = 1'b0;
      lookup_active = 1'b0;

      @(negedge clk);
      chk("rst_upd_ready", 64'(upd_ready), 64'd0);
      chk("rst_outs", 64'({flush_busy, stall_fetch, wr_en, inv_en}), 64'd0);
      chk("rst_fields", 64'({wr_pc, wr_target, wr_taken, inv_ix}), 64'd0);
      cyc();
      reset = 1'b0;
      cyc();

      // Back-to-back updates with a free port.
      for (int i = 0; i < 4; i++)
         drive_upd(16'h3000 + 16'(2 * i), 16'h4000 + 16'(i), i[0], 1'b1);
      @(negedge clk);
      chk("s1_last_wr", 64'(wr_en), 64'd1);
      cyc();
      @(negedge clk);
      chk("s1_idle", 64'(wr_en), 64'd0);
      cyc();
      chk("s1_drained", 64'(sb.size()), 64'd0);

      // Fetch holds the port: FIFO fills, then starvation forces a write.
      lookup_active = 1'b1;
      for (int i = 0; i < 5; i++)
         drive_upd(16'h5000 + 16'(i), 16'h6000 + 16'(i), 1'b1, i < 4);
      for (int n = 6; n <= 10; n++) begin
         @(negedge clk);
         chk("s2_stall", 64'(stall_fetch), 64'(n == 10));
         chk("s2_wr_en", 64'(wr_en), 64'(n == 10));
         cyc();
      end
      drive_upd(16'h5100, 16'h6100, 1'b0, 1'b1);

      // Flush with a full queue: entries are discarded, walk 0..7.
      flush_req = 1'b1;
      @(negedge clk);
      chk("s3_flush_rdy", 64'(upd_ready), 64'd0);
      chk("s3_flush_wr", 64'(wr_en), 64'd0);
      sb.delete();
      expect_walk(8);
      cyc();
      flush_req     = 1'b0;
      lookup_active = 1'b0;
      for (int i = 0; i < 8; i++) begin
         flush_req = (i == 2);
         @(negedge clk);
         chk("s3_busy", 64'(flush_busy), 64'd1);
         cyc();
      end
      flush_req = 1'b0;
      @(negedge clk);
      chk("s3_done", 64'({flush_busy, inv_en}), 64'd0);
      cyc();
      chk("s3_walk_len", 64'(inv_q.size()), 64'd0);

      // Update racing a flush request loses.
      upd_valid  = 1'b1;
      upd_pc     = 16'hDEAD;
      upd_target = 16'hBEEF;
      flush_req  = 1'b1;
      @(negedge clk);
      chk("s4_rdy", 64'(upd_ready), 64'd0);
      expect_walk(8);
      cyc();
      upd_valid = 1'b0;
      flush_req = 1'b0;
      repeat (10) cyc();
      chk("s4_walk_len", 64'(inv_q.size()), 64'd0);
      chk("s4_no_wr", 64'(sb.size()), 64'd0);

      // Two queued, then push+pop on alternate cycles across pointer wrap.
      lookup_active = 1'b1;
      drive_upd(16'h7000, 16'h7100, 1'b1, 1'b1);
      drive_upd(16'h7002, 16'h7102, 1'b0, 1'b1);
      for (int j = 0; j < 12; j++) begin
         if (j[0]) begin
            lookup_active = 1'b0;
            drive_upd(16'h7004 + 16'(j), 16'h7200 + 16'(j), j[1], 1'b1);
         end else begin
            lookup_active = 1'b1;
            cyc();
         end
      end
      lookup_active = 1'b0;
      repeat (4) cyc();
      chk("s5_drained", 64'(sb.size()), 64'd0);

      // Reset in the middle of a walk abandons it.
      flush_req = 1'b1;
      expect_walk(3);
      cyc();
      flush_req = 1'b0;
      repeat (3) cyc();
      reset = 1'b1;
      @(negedge clk);
      chk("s6_rst_outs",
          64'({upd_ready, flush_busy, stall_fetch, wr_en, inv_en}), 64'd0);
      chk("s6_rst_ix", 64'(inv_ix), 64'd0);
      cyc();
      reset = 1'b0;
      @(negedge clk);
      chk("s6_run_rdy", 64'(upd_ready), 64'd1);
      chk("s6_run_busy", 64'(flush_busy), 64'd0);
      repeat (10) cyc();
      chk("s6_walk_len", 64'(inv_q.size()), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/bp_update_scheduler.md
# bp_update_scheduler

Sequences all writes into the branch predictor table. Resolved control-flow updates leaving the pipeline are buffered in a small FIFO and issued one per cycle on the predictor's single table port, yielding to fetch-stage lookups. Software/exception-driven flushes are sequenced as a walk that invalidates every predictor entry. A starvation guard briefly stalls fetch so that updates cannot be held off indefinitely.

## Interface
- DEPTH, 4: update FIFO entries; power of two, ≥2.
- NUM_ENTRIES, 8: predictor entries to invalidate on flush; power of two.
- STARVE_LIMIT, 8: consecutive blocked cycles before fetch is stalled; ≥1.

- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- upd_valid  in  1  resolved BR/JMP/JSR/JSRR/TRAP exiting the pipeline.
- upd_pc  in  16  PC of that instruction (predictor tag).
- upd_target  in  16  resolved target.
- upd_taken  in  1  resolved direction.
- upd_ready  out  1  update accepted at this edge if upd_valid && upd_ready.
- flush_req  in  1  request to invalidate all predictor entries.
- flush_busy  out  1  invalidation walk in progress.
- lookup_active  in  1  fetch is using the table port this cycle.
- stall_fetch  out  1  fetch must not look up this cycle.
- wr_en  out  1  write head update to predictor.
- wr_pc / wr_target  out  16 each  head entry fields; 0 when wr_en=0.
- wr_taken  out  1  head direction; 0 when wr_en=0.
- inv_en  out  1  invalidate entry inv_ix.
- inv_ix  out  log2(NUM_ENTRIES)  entry being invalidated.

## Operation
- States: RUN, FLUSH. Reset → RUN, FIFO empty (rd/wr pointers 0, count 0), inv_ix 0, starve_cnt 0.
- Port grant: grant = !lookup_active || stall_fetch.
- RUN:
  - upd_ready = !full && !flush_req.
  - Push on upd_valid && upd_ready.
  - wr_en = !empty && grant; the head pops on wr_en.
  - Push and pop in the same cycle leaves count unchanged. Pointers wrap modulo DEPTH. Count is log2(DEPTH)+1 bits.
- flush_req in RUN: at that edge the FIFO is cleared (queued updates discarded as stale), inv_ix←0, state→FLUSH. No wr_en is issued in that cycle; the flush has priority over a concurrent upd_valid, which is not accepted.
- FLUSH:
  - upd_ready=0, flush_busy=1, wr_en=0.
  - inv_en = grant. When inv_en, inv_ix increments.
  - When inv_ix==NUM_ENTRIES-1 and inv_en is asserted, the walk ends: state→RUN, inv_ix→0.
  - flush_req during FLUSH is ignored; the walk is not restarted.
- Starvation:
  - pending = (RUN && !empty) || FLUSH.
  - starve_cnt increments (saturating at STARVE_LIMIT) each cycle that pending && lookup_active && !stall_fetch.
  - It clears on any wr_en/inv_en or when !pending.
  - stall_fetch = pending && starve_cnt==STARVE_LIMIT (combinational from registered state).
- Reset mid-flush or with a non-empty FIFO: everything returns to the reset state immediately; partially completed invalidations are not resumed.

## Timing
- Reset values: upd_ready 0 while reset is asserted; flush_busy, stall_fetch, wr_en, inv_en 0; wr_* and inv_ix 0.
- Update latency: an update accepted at edge N can appear on wr_en in cycle N+1 at the earliest. There is no FIFO bypass.
- Throughput: one write or one invalidate per cycle.
- A full flush takes NUM_ENTRIES granted cycles after the edge on which flush_req was sampled.
- wr_en/inv_en/stall_fetch are combinational from registered state plus lookup_active. upd_ready is combinational from registered state plus flush_req.
- The predictor performs the write at the edge ending the cycle in which wr_en/inv_en is high.

## Test plan
- Reset, then 4 back-to-back updates with lookup_active=0 (pc 0x3000..0x3006) → wr_en high cycles 1–4 after the first push, in order; upd_ready stays 1.
- lookup_active=1 held, push 5 updates → first 4 accepted, upd_ready=0 on the 5th. After STARVE_LIMIT=8 blocked cycles stall_fetch=1 and wr_en=1, then starve_cnt clears.
- FIFO full and flush_req pulsed → queue discarded (no wr_en ever for those 4). inv_en with inv_ix 0..7 over 8 cycles with lookup_active=0; flush_busy falls after inv_ix=7.
- upd_valid and flush_req in the same cycle → upd_ready=0, update never written, walk starts.
- FIFO with 2 entries, lookup_active alternating 1/0 → simultaneous push/pop keeps count correct; pointer wrap after 6 pushes preserves order.
- reset asserted mid-flush at inv_ix=3 → all outputs 0 immediately; after release state is RUN, upd_ready=1, no further inv_en.
